// File: rtl/uart_tx_param_pkg.sv
// Shared constants, FSM state type and frame-length helper for the parametrised UART transmitter.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_t;

    // Total clk cycles occupied by one frame on the serial line.
    function automatic int frame_len(input int clks_per_bit, input int data_bits,
                                     input int parity, input int stop_bits);
        return clks_per_bit * (1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits);
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Host-side bus of the UART transmitter: write strobe/data in, status flags and serial line out.
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8,
    parameter int AW        = 2
);
    logic                 TX_EN;
    logic [DATA_BITS-1:0] TX_DATA;
    logic                 TX_STATUS;
    logic                 TX_FULL;
    logic [AW:0]          TX_COUNT;
    logic                 TX_OVF;
    logic                 UART_TX;

    modport master (
        output TX_EN, TX_DATA,
        input  TX_STATUS, TX_FULL, TX_COUNT, TX_OVF, UART_TX
    );

    modport slave (
        input  TX_EN, TX_DATA,
        output TX_STATUS, TX_FULL, TX_COUNT, TX_OVF, UART_TX
    );
endinterface

// File: rtl/uart_tx_param_fifo.sv
// Small synchronous FIFO; the head word is visible combinationally so the FSM can pop and load in one edge.
module uart_tx_fifo #(
    parameter  int DATA_BITS  = 8,
    parameter  int FIFO_DEPTH = 4,
    localparam int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic [AW:0]          count,
    output logic                 full,
    output logic                 empty
);
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic                 do_push, do_pop;

    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    // Full is judged on the registered count, so a push while full is dropped even if a pop coincides.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-buffered writes, internal bit timing, optional parity, 1 or 2 stop bits.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter  int DATA_BITS    = 8,
    parameter  int CLKS_PER_BIT = 5208,
    parameter  int PARITY       = 0,
    parameter  int STOP_BITS    = 1,
    parameter  int FIFO_DEPTH   = 4,
    localparam int AW           = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_param_if.slave   bus
);
    // The stop period may span two bit times, so the timer is sized for the longer of the two.
    localparam int TW = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 ovf_q, ovf_d;
    logic                 last_tick;
    logic                 pop;
    logic                 uart_tx;
    logic [DATA_BITS-1:0] fifo_dout;
    logic [AW:0]          fifo_count;
    logic                 fifo_full, fifo_empty;

    uart_tx_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.TX_EN),
        .pop   (pop),
        .din   (bus.TX_DATA),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        pop       = 1'b0;
        ovf_d     = ovf_q | (bus.TX_EN & fifo_full);
        last_tick = (state_q == STOP) ? (timer_q == STOP_LAST) : (timer_q == BIT_LAST);
        if (state_q != IDLE) begin
            timer_d = last_tick ? '0 : timer_q + TW'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_dout;
                    parity_d  = (PARITY == PARITY_EVEN) ? ^fifo_dout : ~^fifo_dout;
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (last_tick) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (last_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        state_d = (PARITY != PARITY_NONE) ? PAR : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            PAR: begin
                if (last_tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more data is queued.
                if (last_tick) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_d   = fifo_dout;
                        parity_d  = (PARITY == PARITY_EVEN) ? ^fifo_dout : ~^fifo_dout;
                        bit_cnt_d = '0;
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        uart_tx = 1'b1;
        unique case (state_q)
            START:   uart_tx = 1'b0;
            DATA:    uart_tx = shift_q[0];
            PAR:     uart_tx = parity_q;
            default: uart_tx = 1'b1;
        endcase
    end

    assign bus.UART_TX   = uart_tx;
    assign bus.TX_STATUS = (state_q == IDLE) && fifo_empty;
    assign bus.TX_FULL   = fifo_full;
    assign bus.TX_COUNT  = fifo_count;
    assign bus.TX_OVF    = ovf_q;
endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations share one clock; the line is logged every cycle and frames are rebuilt from data.
module tb_uart_tx_param;
    localparam int CPB  = 4;
    localparam int NLOG = 8192;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] en    = '0;
    logic [8:0] din [3];
    logic [2:0] line, status, full, ovf;
    logic [2:0] cnt [3];
    logic       line_log   [3][NLOG];
    logic       status_log [3][NLOG];
    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int nb  [3] = '{8, 7, 7};
    int par [3] = '{0, 2, 1};
    int sb  [3] = '{1, 2, 1};

    always #5 clk = ~clk;

    uart_tx_param_if #(.DATA_BITS(8), .AW(2)) if_a ();
    uart_tx_param_if #(.DATA_BITS(7), .AW(2)) if_b ();
    uart_tx_param_if #(.DATA_BITS(7), .AW(2)) if_c ();

    assign if_a.TX_EN = en[0];  assign if_a.TX_DATA = din[0][7:0];
    assign if_b.TX_EN = en[1];  assign if_b.TX_DATA = din[1][6:0];
    assign if_c.TX_EN = en[2];  assign if_c.TX_DATA = din[2][6:0];
    assign line   = {if_c.UART_TX,   if_b.UART_TX,   if_a.UART_TX};
    assign status = {if_c.TX_STATUS, if_b.TX_STATUS, if_a.TX_STATUS};
    assign full   = {if_c.TX_FULL,   if_b.TX_FULL,   if_a.TX_FULL};
    assign ovf    = {if_c.TX_OVF,    if_b.TX_OVF,    if_a.TX_OVF};
    assign cnt[0] = if_a.TX_COUNT;
    assign cnt[1] = if_b.TX_COUNT;
    assign cnt[2] = if_c.TX_COUNT;

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_a (.clk(clk), .reset(rst_n), .bus(if_a.slave));
    uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4))
        u_b (.clk(clk), .reset(rst_n), .bus(if_b.slave));
    uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_c (.clk(clk), .reset(rst_n), .bus(if_c.slave));

    // Sample index k holds the outputs as they stand after the k-th rising edge.
    task automatic tick();
        @(negedge clk);
        if (cyc < NLOG) begin
            for (int i = 0; i < 3; i++) begin
                line_log[i][cyc]   = line[i];
                status_log[i][cyc] = status[i];
            end
        end
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int idx, input logic [8:0] d, output int k);
        k        = cyc;
        en[idx]  = 1'b1;
        din[idx] = d;
        tick();
        en[idx]  = 1'b0;
        din[idx] = 9'($urandom);
    endtask

    function automatic int flen(input int idx);
        return CPB * (1 + nb[idx] + ((par[idx] != 0) ? 1 : 0) + sb[idx]);
    endfunction

    // Expected frame: start 0, data LSB first, optional parity, stop 1s; each bit held CPB cycles.
    task automatic check_frame(input int idx, input int start, input logic [8:0] d, input string tag);
        bit            bits [$];
        int            ones;
        logic          pb;
        logic [CPB-1:0] got;
        bits.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < nb[idx]; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par[idx] != 0) begin
            pb = (ones % 2 == 1);
            if (par[idx] == 1) pb = ~pb;
            bits.push_back(pb);
        end
        for (int s = 0; s < sb[idx]; s++) bits.push_back(1'b1);
        for (int j = 0; j < bits.size(); j++) begin
            for (int c = 0; c < CPB; c++) got[c] = line_log[idx][start + j * CPB + c];
            check($sformatf("%s.bit%0d", tag, j), 32'(got), bits[j] ? 32'hF : 32'h0);
        end
    endtask

    task automatic check_end(input int idx, input int start, input int nfr, input string tag);
        int e;
        e = start + nfr * flen(idx);
        check({tag, ".busy_last"}, 32'(status_log[idx][e - 1]), 32'd0);
        check({tag, ".idle_after"}, 32'(status_log[idx][e]), 32'd1);
        check({tag, ".line_idle"}, 32'(line_log[idx][e]), 32'd1);
    endtask

    initial begin
        int k, kk, n;
        logic [8:0] vals [6];

        for (int i = 0; i < 3; i++) din[i] = '0;
        tick();
        tick();
        for (int i = 0; i < 3; i++)
            check($sformatf("reset%0d", i), 32'({line[i], status[i], full[i], ovf[i], cnt[i]}), 32'b1100000);
        rst_n = 1'b1;
        tick();
        tick();

        // Single 8N1 frame of 0xA5
        push(0, 9'h0A5, k);
        check("a5.status_drop", 32'(status[0]), 32'd0);
        check("a5.count", 32'(cnt[0]), 32'd1);
        run_to(k + 1 + 40 + 2);
        check("a5.line_at_push", 32'(line_log[0][k]), 32'd1);
        check_frame(0, k + 1, 9'h0A5, "a5");
        check_end(0, k + 1, 1, "a5");

        // 7-bit even parity with 2 stop bits, and 7-bit odd parity
        push(1, 9'h003, k);
        push(2, 9'h003, kk);
        run_to(kk + 1 + flen(1) + 2);
        check_frame(1, k + 1, 9'h003, "even7");
        check_end(1, k + 1, 1, "even7");
        check_frame(2, kk + 1, 9'h003, "odd7");
        check_end(2, kk + 1, 1, "odd7");

        // Four back-to-back writes
        vals[0] = 9'h011; vals[1] = 9'h022; vals[2] = 9'h033; vals[3] = 9'h044;
        k = cyc;
        for (int i = 0; i < 4; i++) begin
            push(0, vals[i], kk);
            check($sformatf("b2b.full%0d", i), 32'(full[0]), 32'd0);
        end
        check("b2b.count", 32'(cnt[0]), 32'd3);
        run_to(k + 1 + 4 * 40 + 2);
        for (int i = 0; i < 4; i++) check_frame(0, k + 1 + 40 * i, vals[i], $sformatf("b2b%0d", i));
        check_end(0, k + 1, 4, "b2b");

        // Six writes into a 4-deep FIFO: sixth dropped, overflow sticky
        k = cyc;
        for (int i = 0; i < 6; i++) begin
            vals[i] = 9'($urandom_range(0, 255));
            push(0, vals[i], kk);
            if (i == 4) check("ovf.full_at5", 32'({full[0], ovf[0], cnt[0]}), 32'b10100);
        end
        check("ovf.after6", 32'({full[0], ovf[0], cnt[0]}), 32'b11100);
        run_to(k + 1 + 5 * 40 + 2);
        for (int i = 0; i < 5; i++) check_frame(0, k + 1 + 40 * i, vals[i], $sformatf("ovf%0d", i));
        check_end(0, k + 1, 5, "ovf");
        check("ovf.sticky", 32'(ovf[0]), 32'd1);

        // Push coinciding with the pop edge at occupancy 2
        k = cyc;
        for (int i = 0; i < 3; i++) begin
            vals[i] = 9'($urandom_range(0, 255));
            push(0, vals[i], kk);
        end
        vals[3] = 9'($urandom_range(0, 255));
        run_to(k + 41);
        check("pp.count_before", 32'(cnt[0]), 32'd2);
        push(0, vals[3], kk);
        check("pp.count_after", 32'(cnt[0]), 32'd2);
        run_to(k + 1 + 4 * 40 + 2);
        for (int i = 0; i < 4; i++) check_frame(0, k + 1 + 40 * i, vals[i], $sformatf("pp%0d", i));
        check_end(0, k + 1, 4, "pp");

        // Random bursts on every configuration
        for (int r = 0; r < 3; r++) begin
            for (int idx = 0; idx < 3; idx++) begin
                run_to(cyc + $urandom_range(0, 7));
                n = $urandom_range(1, 5);
                k = cyc;
                for (int i = 0; i < n; i++) begin
                    vals[i] = 9'($urandom_range(0, 511));
                    push(idx, vals[i], kk);
                end
                run_to(k + 1 + n * flen(idx) + 2);
                for (int i = 0; i < n; i++)
                    check_frame(idx, k + 1 + flen(idx) * i, vals[i], $sformatf("rnd%0d_%0d_%0d", r, idx, i));
                check_end(idx, k + 1, n, $sformatf("rnd%0d_%0d", r, idx));
            end
        end

        // Reset during the third data bit, with more words queued
        push(0, 9'h000, k);
        for (int i = 0; i < 3; i++) push(0, 9'($urandom_range(0, 255)), kk);
        run_to(k + 15);
        check("rst.mid_low", 32'(line[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst.async", 32'({line[0], status[0], full[0], ovf[0], cnt[0]}), 32'b1100000);
        tick();
        rst_n = 1'b1;
        tick();
        push(0, 9'h05A, k);
        run_to(k + 1 + 40 + 12);
        check_frame(0, k + 1, 9'h05A, "post_rst");
        check_end(0, k + 1, 1, "post_rst");
        check("post_rst.quiet", 32'({line[0], status[0], cnt[0]}), 32'b11000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter for the CPU peripheral bus, and successor to the fixed 8-bit, 16-tick transmitter. It uses one system clock and derives bit timing internally, so no separate baud clock is needed. It is configurable in data width, parity and stop bits, and buffers writes in a small FIFO so software can queue bytes back-to-back. Frames go out LSB-first on UART_TX with no idle gap between queued frames.

Parameters:
DATA_BITS, 8, payload bits per frame (legal 5..9)
CLKS_PER_BIT, 5208, clk cycles per serial bit (50 MHz / 9600 baud); legal >= 2
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits (1 or 2)
FIFO_DEPTH, 4, TX FIFO entries; power of two, >= 2
AW, $clog2(FIFO_DEPTH), FIFO pointer width (derived; never overridden)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  asynchronous, active-low reset
TX_EN  input  1  write strobe; one-cycle pulse pushes TX_DATA into the FIFO
TX_DATA  input  DATA_BITS  payload to queue
TX_STATUS  output  1  1 = FIFO empty and line idle (all data sent)
TX_FULL  output  1  1 = FIFO full; writes are dropped
TX_COUNT  output  AW+1  FIFO occupancy, 0..FIFO_DEPTH
TX_OVF  output  1  sticky overflow flag; set by a write while full
UART_TX  output  1  serial line, idle high

Behaviour:
- Reset (reset=0, asynchronous):
  - UART_TX=1, TX_STATUS=1, TX_FULL=0, TX_COUNT=0, TX_OVF=0.
  - FSM goes to IDLE; bit timer and bit counter go to 0; FIFO pointers go to 0.
  - Reset mid-frame aborts the frame immediately. The line returns high at once and queued data is discarded.
- FIFO push:
  - At a posedge with TX_EN=1 and registered TX_FULL=0, TX_DATA is written.
  - TX_EN=1 with TX_FULL=1 drops the data and sets TX_OVF=1. TX_OVF is cleared only by reset.
  - A push and a pop in the same cycle leave TX_COUNT unchanged. A push while full is dropped even if a pop occurs that same cycle.
- FIFO pop: done only by the FSM, only when registered TX_COUNT != 0. There is no same-cycle bypass.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: if TX_COUNT != 0, pop the head into the shift register and enter START. UART_TX=0 from that edge on.
  - Each non-IDLE state holds UART_TX for exactly CLKS_PER_BIT cycles. The bit timer counts 0..CLKS_PER_BIT-1; the state advances on the terminal count.
  - START -> DATA.
  - DATA: shifts out bit 0 first, DATA_BITS bits, then goes to PAR if PARITY != 0, otherwise to STOP.
  - PAR drives the parity bit: ^data for even, ~^data for odd. Parity is computed from the popped word, not from the shifting register.
  - STOP drives 1 for STOP_BITS*CLKS_PER_BIT cycles. On the terminal count:
    - if TX_COUNT != 0, pop and go directly to START (zero idle gap);
    - otherwise go to IDLE.
- Latency: TX_EN sampled at edge N into an empty, idle block gives a falling start bit after edge N+1.
- Frame length: CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
- TX_STATUS: combinational from registered state, 1 iff FSM==IDLE and TX_COUNT==0. It drops to 0 the cycle after the push edge.
- TX_FULL is 1 iff TX_COUNT==FIFO_DEPTH.
- Pointers wrap modulo FIFO_DEPTH. TX_COUNT never exceeds FIFO_DEPTH and never underflows.
- Changing TX_DATA after the push edge has no effect on the queued word.

Decomposition:
- Package uart_pkg holds:
  - PARITY_NONE/ODD/EVEN constants;
  - the tx_state_t enum (IDLE, START, DATA, PAR, STOP);
  - the frame_len helper function.
- Sub-module uart_tx_fifo: synchronous FIFO with DATA_BITS width and FIFO_DEPTH depth. Its ports are push, pop, din, dout, count, full and empty, and it shares clk and reset.
- The FSM, bit timer and shifter stay in uart_tx_param.

Test Plan (bench uses CLKS_PER_BIT=4):
- Reset then a single write of 8'hA5 with 8N1: line low after edge N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high. TX_STATUS returns to 1 exactly 40 cycles after the start bit.
- PARITY=2 (even), DATA_BITS=7, data 7'h03: parity bit 0. With PARITY=1 the same data gives parity bit 1. STOP_BITS=2 stretches the stop period to 8 cycles.
- 4 writes on consecutive cycles (0x11, 0x22, 0x33, 0x44): TX_COUNT reaches 3 (one already popped), TX_FULL stays 0. The 4 frames are sent back-to-back with no high gap between the stop bit and the next start bit.
- 6 consecutive writes with FIFO_DEPTH=4: TX_FULL=1 and TX_OVF=1. The 6th byte is never transmitted; bytes 1-5 are sent in order.
- Push and pop in the same cycle at TX_COUNT=2: TX_COUNT stays 2 and no data is lost.
- Assert reset during the 3rd data bit: UART_TX goes to 1 asynchronously and all outputs take their reset values. A subsequent write of 8'h5A transmits a clean frame.
